delay_sched_ctrl: RTL and testbench

- Schedule and address controller for a dual-port SRAM delay buffer. It plays the role of the read and write schedule and address generators inside a unified-buffer memtile.
- Two identical nested-loop schedule generators decide the cycle on which each write and each read happens. Circular address pointers place write and read a fixed number of entries apart.
- Sits between the app-level tile config and a raw SRAM macro. It replaces hard-wired generator constants with a sequenced, observable controller.

---
 rtl/delay_sched_pkg.sv | 31 +++
 rtl/delay_sched_ctrl_if.sv | 15 +
 rtl/loop_sched_gen.sv | 81 ++++++++
 rtl/delay_sched_ctrl.sv | 154 +++++++++++++++
 tb/tb_delay_sched_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/delay_sched_pkg.sv
// Shared types and constants for the delay-buffer schedule controller.
// The controller and its schedule generators both import this package.
package delay_sched_pkg;

  localparam int DIMS_MAX = 6;
  localparam int CW       = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_e;

  typedef struct packed {
    logic [3:0]             dim;
    logic [DIMS_MAX*CW-1:0] ranges;
    logic [DIMS_MAX*CW-1:0] strides;
    logic [CW-1:0]          start;
  } sched_cfg_t;

  // Zero means a single loop; anything deeper than the hardware supports saturates.
  function automatic logic [3:0] clamp_dim(input logic [3:0] dim, input int unsigned dim_max);
    logic [3:0] lim;
    lim = 4'(dim_max);
    if (dim == 4'd0) return 4'd1;
    if (dim > lim) return lim;
    return dim;
  endfunction

endpackage

// File: rtl/delay_sched_ctrl_if.sv
// SRAM-side port bundle: write/read enables, addresses and read-data valid.
interface delay_sched_ctrl_if #(
  parameter int AW = 9
);

  logic          wen;
  logic [AW-1:0] waddr;
  logic          ren;
  logic [AW-1:0] raddr;
  logic          valid_out;

  modport master (output wen, waddr, ren, raddr, valid_out);
  modport slave  (input  wen, waddr, ren, raddr, valid_out);

endinterface

// File: rtl/loop_sched_gen.sv
// Nested-loop schedule generator: one event per matching cycle, advancing an
// odometer-style iterator and adding the stride of the dimension that steps.
module loop_sched_gen #(
  parameter int DIMS = 6,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step_en,
  input  logic [CW-1:0]      cycle,
  input  logic [DIMS*CW-1:0] ranges,
  input  logic [DIMS*CW-1:0] strides,
  input  logic [CW-1:0]      start,
  output logic               fire,
  output logic               exhausted
);
  import delay_sched_pkg::*;

  localparam int IW = (DIMS > 1) ? $clog2(DIMS) : 1;

  logic [DIMS-1:0] can_inc;
  logic            carry_found;
  logic [IW-1:0]   carry_dim;
  logic [CW-1:0]   time_reg;
  logic            exh_reg;

  assign fire      = step_en && !exh_reg && (cycle == time_reg);
  assign exhausted = exh_reg;

  // Ranges arrive already clamped to >= 1, so range-1 never underflows.
  generate
    for (genvar gi = 0; gi < DIMS; gi++) begin : g_dim
      logic [CW-1:0] idx_reg;

      assign can_inc[gi] = idx_reg < (ranges[gi*CW +: CW] - CW'(1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          idx_reg <= '0;
        end else if (load) begin
          idx_reg <= '0;
        end else if (fire && carry_found) begin
          if (carry_dim == IW'(gi)) begin
            idx_reg <= idx_reg + CW'(1);
          end else if (IW'(gi) < carry_dim) begin
            idx_reg <= '0;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    carry_found = 1'b0;
    carry_dim   = '0;
    for (int d = 0; d < DIMS; d++) begin
      if (!carry_found && can_inc[d]) begin
        carry_found = 1'b1;
        carry_dim   = IW'(d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_reg <= '0;
      exh_reg  <= 1'b0;
    end else if (load) begin
      time_reg <= start;
      exh_reg  <= 1'b0;
    end else if (fire) begin
      if (carry_found) begin
        time_reg <= time_reg + strides[carry_dim*CW +: CW];
      end else begin
        exh_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_sched_ctrl.sv
// Schedule and address controller for a dual-port SRAM delay buffer: two loop
// schedule generators drive circular write/read pointers through a small FSM.
module delay_sched_ctrl #(
  parameter int DIMS = delay_sched_pkg::DIMS_MAX,
  parameter int CW   = delay_sched_pkg::CW,
  parameter int AW   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               cfg_en,
  input  logic [3:0]         cfg_dim,
  input  logic [DIMS*CW-1:0] cfg_ranges,
  input  logic [DIMS*CW-1:0] cfg_strides,
  input  logic [CW-1:0]      cfg_wr_sched_start,
  input  logic [CW-1:0]      cfg_rd_sched_start,
  input  logic [AW-1:0]      cfg_wr_addr_start,
  delay_sched_ctrl_if.master sram,
  output logic               busy,
  output logic               done
);
  import delay_sched_pkg::*;

  ctrl_state_e        state_reg;
  logic [CW-1:0]      cycle_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic               wen_reg;
  logic [AW-1:0]      waddr_reg;
  logic               ren_reg;
  logic [AW-1:0]      raddr_reg;
  logic               valid_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [3:0]         dim_eff;
  logic [DIMS*CW-1:0] eff_ranges;
  logic               load;
  logic               step_en;
  logic               wr_fire;
  logic               rd_fire;
  logic               wr_exh;
  logic               rd_exh;

  assign dim_eff = clamp_dim(cfg_dim, DIMS);

  // Inactive dimensions look like range 1 so the carry search never selects them.
  generate
    for (genvar gi = 0; gi < DIMS; gi++) begin : g_range
      assign eff_ranges[gi*CW +: CW] =
        ((4'(gi) >= dim_eff) || (cfg_ranges[gi*CW +: CW] == '0)) ? CW'(1)
                                                                 : cfg_ranges[gi*CW +: CW];
    end
  endgenerate

  // flush outranks any event matching in the same cycle.
  assign load    = cfg_en && (flush || (state_reg == IDLE));
  assign step_en = cfg_en && !flush && (state_reg == RUN);

  loop_sched_gen #(.DIMS(DIMS), .CW(CW)) u_wr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step_en   (step_en),
    .cycle     (cycle_reg),
    .ranges    (eff_ranges),
    .strides   (cfg_strides),
    .start     (cfg_wr_sched_start),
    .fire      (wr_fire),
    .exhausted (wr_exh)
  );

  loop_sched_gen #(.DIMS(DIMS), .CW(CW)) u_rd_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step_en   (step_en),
    .cycle     (cycle_reg),
    .ranges    (eff_ranges),
    .strides   (cfg_strides),
    .start     (cfg_rd_sched_start),
    .fire      (rd_fire),
    .exhausted (rd_exh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cycle_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      wen_reg    <= 1'b0;
      waddr_reg  <= '0;
      ren_reg    <= 1'b0;
      raddr_reg  <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      wen_reg   <= wr_fire;
      ren_reg   <= rd_fire;
      valid_reg <= ren_reg && cfg_en;
      if (wr_fire) begin
        waddr_reg  <= wr_ptr_reg;
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_fire) begin
        raddr_reg  <= rd_ptr_reg;
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end

      if (!cfg_en) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b0;
      end else if (load) begin
        state_reg  <= RUN;
        busy_reg   <= 1'b1;
        done_reg   <= 1'b0;
        cycle_reg  <= '0;
        wr_ptr_reg <= cfg_wr_addr_start;
        rd_ptr_reg <= '0;
      end else begin
        case (state_reg)
          RUN: begin
            cycle_reg <= cycle_reg + CW'(1);
            if (wr_exh && rd_exh) state_reg <= DRAIN;
          end
          DRAIN: begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
          DONE: state_reg <= DONE;
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Dropping the tile enable must kill any in-flight strobe immediately.
  assign sram.wen       = wen_reg && cfg_en;
  assign sram.ren       = ren_reg && cfg_en;
  assign sram.waddr     = waddr_reg;
  assign sram.raddr     = raddr_reg;
  assign sram.valid_out = valid_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

endmodule

// File: tb/tb_delay_sched_ctrl.sv
// Directed bench for delay_sched_ctrl; cycle k means k cycles after entering RUN.
module tb_delay_sched_ctrl;
  localparam int DIMS = 6;
  localparam int CW   = 16;
  localparam int AW   = 9;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic               cfg_en = 1'b0;
  logic [3:0]         cfg_dim = '0;
  logic [DIMS*CW-1:0] cfg_ranges = '0;
  logic [DIMS*CW-1:0] cfg_strides = '0;
  logic [CW-1:0]      cfg_wr_sched_start = '0;
  logic [CW-1:0]      cfg_rd_sched_start = '0;
  logic [AW-1:0]      cfg_wr_addr_start = '0;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  delay_sched_ctrl_if #(.AW(AW)) sram_if ();

  delay_sched_ctrl #(.DIMS(DIMS), .CW(CW), .AW(AW)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .cfg_en             (cfg_en),
    .cfg_dim            (cfg_dim),
    .cfg_ranges         (cfg_ranges),
    .cfg_strides        (cfg_strides),
    .cfg_wr_sched_start (cfg_wr_sched_start),
    .cfg_rd_sched_start (cfg_rd_sched_start),
    .cfg_wr_addr_start  (cfg_wr_addr_start),
    .sram               (sram_if),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [3:0] dim, input logic [CW-1:0] r0, input logic [CW-1:0] r1,
                         input logic [CW-1:0] s0, input logic [CW-1:0] s1,
                         input logic [CW-1:0] ws, input logic [CW-1:0] rs, input logic [AW-1:0] wa);
    cfg_dim                 = dim;
    cfg_ranges              = '0;
    cfg_strides             = '0;
    cfg_ranges[CW-1:0]      = r0;
    cfg_ranges[2*CW-1:CW]   = r1;
    cfg_strides[CW-1:0]     = s0;
    cfg_strides[2*CW-1:CW]  = s1;
    cfg_wr_sched_start      = ws;
    cfg_rd_sched_start      = rs;
    cfg_wr_addr_start       = wa;
  endtask

  // Leaves the bench at the sampling point of cycle 0 of a fresh run.
  task automatic start_run();
    cfg_en = 1'b0;
    @(negedge clk);
    cfg_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0]   wmask;
    logic [AW-1:0] wrap_addr [4];
    int            cnt_w;
    int            cnt_r;
    int            nw;
    int            nr;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_wen", 32'(sram_if.wen), 0);
    chk("reset_ren", 32'(sram_if.ren), 0);
    chk("reset_valid", 32'(sram_if.valid_out), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);

    // 1: single loop of 8, write delay 3 entries, reads start 3 cycles later
    set_cfg(4'd1, 16'd8, 16'd0, 16'd1, 16'd0, 16'd2, 16'd5, 9'd3);
    start_run();
    for (int k = 0; k <= 16; k++) begin
      chk($sformatf("t1_wen_c%0d", k), 32'(sram_if.wen), 32'(k >= 3 && k <= 10));
      if (k >= 3 && k <= 10) chk($sformatf("t1_waddr_c%0d", k), 32'(sram_if.waddr), 32'(k));
      chk($sformatf("t1_ren_c%0d", k), 32'(sram_if.ren), 32'(k >= 6 && k <= 13));
      if (k >= 6 && k <= 13) chk($sformatf("t1_raddr_c%0d", k), 32'(sram_if.raddr), 32'(k - 6));
      chk($sformatf("t1_valid_c%0d", k), 32'(sram_if.valid_out), 32'(k >= 7 && k <= 14));
      chk($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k <= 14));
      chk($sformatf("t1_done_c%0d", k), 32'(done), 32'(k >= 15));
      @(negedge clk);
    end

    // 2: two loops {4,3}, delta strides {1,4}: times 0-3,7-10,14-17
    set_cfg(4'd2, 16'd4, 16'd3, 16'd1, 16'd4, 16'd0, 16'd0, 9'd0);
    wmask = 32'h0007_8F1E;
    cnt_w = 0;
    cnt_r = 0;
    nw    = 0;
    nr    = 0;
    start_run();
    for (int k = 0; k <= 21; k++) begin
      chk($sformatf("t2_wen_c%0d", k), 32'(sram_if.wen), 32'(wmask[k]));
      chk($sformatf("t2_ren_c%0d", k), 32'(sram_if.ren), 32'(wmask[k]));
      if (wmask[k]) begin
        chk($sformatf("t2_waddr_c%0d", k), 32'(sram_if.waddr), 32'(nw));
        chk($sformatf("t2_raddr_c%0d", k), 32'(sram_if.raddr), 32'(nr));
        nw++;
        nr++;
      end
      if (k == 19 || k == 20) chk($sformatf("t2_done_c%0d", k), 32'(done), 32'(k == 20));
      cnt_w += int'(sram_if.wen);
      cnt_r += int'(sram_if.ren);
      @(negedge clk);
    end
    chk("t2_wen_count", 32'(cnt_w), 12);
    chk("t2_ren_count", 32'(cnt_r), 12);

    // 3: write pointer wraps past the top of the buffer
    set_cfg(4'd1, 16'd4, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 9'd510);
    wrap_addr = '{9'd510, 9'd511, 9'd0, 9'd1};
    start_run();
    for (int k = 0; k <= 5; k++) begin
      chk($sformatf("t3_wen_c%0d", k), 32'(sram_if.wen), 32'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) chk($sformatf("t3_waddr_c%0d", k), 32'(sram_if.waddr), 32'(wrap_addr[k-1]));
      @(negedge clk);
    end

    // 4: cfg_en dropped after three writes, then re-enabled
    set_cfg(4'd1, 16'd8, 16'd0, 16'd1, 16'd0, 16'd0, 16'd20, 9'd100);
    start_run();
    for (int k = 0; k <= 3; k++) begin
      chk($sformatf("t4_wen_c%0d", k), 32'(sram_if.wen), 32'(k >= 1));
      if (k >= 1) chk($sformatf("t4_waddr_c%0d", k), 32'(sram_if.waddr), 32'(99 + k));
      @(negedge clk);
    end
    chk("t4_wen_before_drop", 32'(sram_if.wen), 1);
    cfg_en = 1'b0;
    #1;
    chk("t4_wen_gated", 32'(sram_if.wen), 0);
    @(negedge clk);
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_idle_wen", 32'(sram_if.wen), 0);
    cfg_en = 1'b1;
    @(negedge clk);
    chk("t4_rerun_busy", 32'(busy), 1);
    chk("t4_rerun_wen_c0", 32'(sram_if.wen), 0);
    @(negedge clk);
    chk("t4_rerun_wen_c1", 32'(sram_if.wen), 1);
    chk("t4_rerun_waddr_c1", 32'(sram_if.waddr), 100);

    // 5: flush lands on the cycle a write is scheduled (times 1,4,7,10)
    set_cfg(4'd1, 16'd4, 16'd0, 16'd3, 16'd0, 16'd1, 16'd50, 9'd7);
    start_run();
    chk("t5_wen_c0", 32'(sram_if.wen), 0);
    @(negedge clk);
    chk("t5_wen_c1", 32'(sram_if.wen), 0);
    @(negedge clk);
    chk("t5_wen_c2", 32'(sram_if.wen), 1);
    chk("t5_waddr_c2", 32'(sram_if.waddr), 7);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_suppressed_wen", 32'(sram_if.wen), 0);
    chk("t5_flush_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t5_re_wen_c1", 32'(sram_if.wen), 0);
    @(negedge clk);
    chk("t5_re_wen_c2", 32'(sram_if.wen), 1);
    chk("t5_re_waddr_c2", 32'(sram_if.waddr), 7);
    repeat (3) @(negedge clk);
    chk("t5_re_wen_c5", 32'(sram_if.wen), 1);
    chk("t5_re_waddr_c5", 32'(sram_if.waddr), 8);

    // 6: dim 0 and range 0 clamp to one event; dim1 range 5 must be ignored
    set_cfg(4'd0, 16'd0, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 9'd3);
    cnt_w = 0;
    cnt_r = 0;
    start_run();
    for (int k = 0; k <= 6; k++) begin
      if (k == 1) begin
        chk("t6_wen_c1", 32'(sram_if.wen), 1);
        chk("t6_waddr_c1", 32'(sram_if.waddr), 3);
      end
      if (k == 2) begin
        chk("t6_valid_c2", 32'(sram_if.valid_out), 1);
        chk("t6_done_c2", 32'(done), 0);
      end
      if (k == 3) chk("t6_done_c3", 32'(done), 1);
      cnt_w += int'(sram_if.wen);
      cnt_r += int'(sram_if.ren);
      @(negedge clk);
    end
    chk("t6_wen_count", 32'(cnt_w), 1);
    chk("t6_ren_count", 32'(cnt_r), 1);

    // 7: asynchronous reset mid-run clears outputs before the next edge
    set_cfg(4'd1, 16'd8, 16'd0, 16'd1, 16'd0, 16'd2, 16'd5, 9'd3);
    start_run();
    repeat (4) @(negedge clk);
    chk("t7_wen_before_rst", 32'(sram_if.wen), 1);
    chk("t7_busy_before_rst", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_wen", 32'(sram_if.wen), 0);
    chk("t7_rst_waddr", 32'(sram_if.waddr), 0);
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    cfg_en = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
